// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: FSM encoding, the
// RV32F funct5 values that matter for writeback routing, and the
// canonical NaN returned when an operation is abandoned.
package fpu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  localparam logic [4:0] FUNCT5_FADD  = 5'b00000;
  localparam logic [4:0] FUNCT5_FCMP  = 5'b10100;
  localparam logic [4:0] FUNCT5_FCVTW = 5'b11000;
  localparam logic [4:0] FUNCT5_FMVX  = 5'b11100;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // instr holds instruction bits [31:2], so full-word bit 4 is instr[2]
  // and funct5 (bits [31:27]) is instr[29:25]. Compares, FCVT.W[U].S and
  // FMV.X.W/FCLASS write the integer register file.
  function automatic logic is_to_int(input logic [29:0] instr);
    logic [4:0] funct5;
    funct5 = instr[29:25];
    return instr[2] && ((funct5 == FUNCT5_FCMP) ||
                        (funct5 == FUNCT5_FCVTW) ||
                        (funct5 == FUNCT5_FMVX));
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_scoreboard.sv
// Single-entry scoreboard for the FP operation in flight. Remembers the
// destination register and which register file it targets, and raises a
// hazard when the instruction in decode reads that register.
module fpu_issue_ctrl_scoreboard
  import fpu_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set,
  input  logic       clear,
  input  logic [4:0] set_rd,
  input  logic       set_to_int,
  input  logic [4:0] chk_rs1,
  input  logic [4:0] chk_rs2,
  input  logic [4:0] chk_rs3,
  input  logic       chk_fp,
  output logic [4:0] pend_rd,
  output logic       to_int,
  output logic       hazard
);

  logic pend_valid;
  logic src_match;

  // Track the in-flight destination; a new accept wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      to_int     <= 1'b0;
    end else if (set) begin
      pend_valid <= 1'b1;
      pend_rd    <= set_rd;
      to_int     <= set_to_int;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end
  end

  // Stall decode only when it reads the same register file; integer x0 is
  // never a real dependency.
  always_comb begin
    src_match = (chk_rs1 == pend_rd) || (chk_rs2 == pend_rd) ||
                (chk_rs3 == pend_rd);
    hazard    = pend_valid && (chk_fp == !to_int) && src_match &&
                !(to_int && (pend_rd == 5'd0));
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller between the execute stage and the micro-coded FPU.
// Accepts one operation, strobes the FPU, waits for busy to fall (or a
// timeout), then holds the result for writeback. Flush abandons the
// operation but still waits out the FPU, which cannot be cancelled.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [29:0]      req_instr_i,
  input  logic [31:0]      req_rs1_i,
  input  logic [31:0]      req_rs2_i,
  input  logic [31:0]      req_rs3_i,
  input  logic [4:0]       req_rd_i,
  input  logic             flush_i,
  output logic             fpu_enable_o,
  output logic [29:0]      fpu_instr_o,
  output logic [31:0]      fpu_rs1_o,
  output logic [31:0]      fpu_rs2_o,
  output logic [31:0]      fpu_rs3_o,
  input  logic             fpu_busy_i,
  input  logic [31:0]      fpu_out_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_to_int_o,
  output logic             wb_timeout_o,
  input  logic [4:0]       chk_rs1_i,
  input  logic [4:0]       chk_rs2_i,
  input  logic [4:0]       chk_rs3_i,
  input  logic             chk_fp_i,
  output logic             hazard_o,
  output logic [CNT_W-1:0] ops_done_o
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             accept;
  logic             sb_clear;

  // Busy also gates accept so a timed-out FPU is drained before reuse.
  assign req_ready_o = (state == ST_IDLE) && !fpu_busy_i && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

  // The pending entry dies on any flush while an operation is live, or when
  // writeback takes the result.
  assign sb_clear = flush_i ? ((state != ST_IDLE) && (state != ST_DRAIN))
                            : ((state == ST_RESP) && wb_ready_i);

  // Issue sequencing with registered FPU and writeback outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      fpu_enable_o <= 1'b0;
      fpu_instr_o  <= '0;
      fpu_rs1_o    <= '0;
      fpu_rs2_o    <= '0;
      fpu_rs3_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_timeout_o <= 1'b0;
      ops_done_o   <= '0;
    end else begin
      fpu_enable_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fpu_instr_o  <= req_instr_i;
            fpu_rs1_o    <= req_rs1_i;
            fpu_rs2_o    <= req_rs2_i;
            fpu_rs3_o    <= req_rs3_i;
            fpu_enable_o <= 1'b1;
            state        <= ST_LAUNCH;
          end
        end
        // The strobe is already out this cycle, so a flush here still
        // launches the FPU and must be drained.
        ST_LAUNCH: begin
          state <= flush_i ? ST_DRAIN : ST_ARM;
        end
        // FPU busy is not meaningful until the cycle after launch.
        ST_ARM: begin
          tmo_cnt <= '0;
          state   <= flush_i ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_i) begin
            state <= ST_DRAIN;
          end else if (!fpu_busy_i) begin
            wb_data_o    <= fpu_out_i;
            wb_timeout_o <= 1'b0;
            wb_valid_o   <= 1'b1;
            state        <= ST_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            wb_data_o    <= CANON_NAN;
            wb_timeout_o <= 1'b1;
            wb_valid_o   <= 1'b1;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (flush_i) begin
            wb_valid_o <= 1'b0;
            state      <= ST_IDLE;
          end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            ops_done_o <= ops_done_o + 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!fpu_busy_i) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  fpu_issue_ctrl_scoreboard u_scoreboard (
    .clk        (clk_i),
    .rst_n      (reset_i),
    .set        (accept),
    .clear      (sb_clear),
    .set_rd     (req_rd_i),
    .set_to_int (is_to_int(req_instr_i)),
    .chk_rs1    (chk_rs1_i),
    .chk_rs2    (chk_rs2_i),
    .chk_rs3    (chk_rs3_i),
    .chk_fp     (chk_fp_i),
    .pend_rd    (wb_rd_o),
    .to_int     (wb_to_int_o),
    .hazard     (hazard_o)
  );

endmodule
